// File: rtl/decryption_r2.sv
// decryption_r2: initiator key confirmation; k = exp mod p, c1 = k^r2, r1 = c2^k.
// Optional WAIT timeout enabled by defining DECRYPTION_R2_TIMEOUT_EN.
module decryption_r2 #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] exp,
  input  logic [31:0] p,
  input  logic [31:0] r2,
  output logic [31:0] c1,
  output logic        c1_valid,
  input  logic        c1_ready,
  input  logic [31:0] c2,
  input  logic        c2_valid,
  output logic [31:0] r1_out,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  typedef enum logic [2:0] {
    IDLE,
    MOD,
    SEND,
    WAIT,
    FIN
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [63:0] exp_q;
  logic [31:0] p_q;
  logic [31:0] r2_q;
  logic [32:0] rem;
  logic [32:0] t;
  logic [32:0] rem_d;
  logic [5:0]  cnt;
  logic        verdict;
  logic        tmo;

`ifdef DECRYPTION_R2_TIMEOUT_EN
  logic [31:0] wcnt;

  // Consecutive WAIT cycles; expires on the last allowed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else if (state == WAIT) wcnt <= wcnt + 32'd1;
    else wcnt <= '0;
  end

  assign tmo = (state == WAIT) &&
               (wcnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  // One restoring-division step: shift in next exp bit, subtract p if it fits.
  always_comb begin
    t     = {rem[31:0], exp_q[cnt]};
    rem_d = t;
    if (t >= {1'b0, p_q}) rem_d = t - {1'b0, p_q};
  end

  // Next-state logic; c2_valid wins over an expiring timeout.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = (p == 32'd0) ? FIN : MOD;
      MOD:  if (cnt == 6'd0) state_d = SEND;
      SEND: if (c1_ready) state_d = WAIT;
      WAIT: if (c2_valid || tmo) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end

  // Datapath: operand latch, remainder, challenge and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q    <= '0;
      p_q      <= '0;
      r2_q     <= '0;
      rem      <= '0;
      cnt      <= '0;
      c1       <= '0;
      c1_valid <= 1'b0;
      r1_out   <= '0;
      verdict  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_q   <= exp;
            p_q     <= p;
            r2_q    <= r2;
            rem     <= '0;
            cnt     <= 6'd63;
            r1_out  <= '0;
            verdict <= (p == 32'd0);
          end
        end
        MOD: begin
          rem <= rem_d;
          if (cnt == 6'd0) begin
            c1       <= rem_d[31:0] ^ r2_q;
            c1_valid <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        SEND: if (c1_ready) c1_valid <= 1'b0;
        WAIT: begin
          if (c2_valid) begin
            if (c2 == 32'd0) verdict <= 1'b1;
            else r1_out <= c2 ^ rem[31:0];
          end else if (tmo) begin
            verdict <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign fail = done & verdict;

endmodule

// File: tb/tb_decryption_r2.sv
// tb_decryption_r2: directed and random exchanges against a modulo/xor model.
// Timeout scenario runs only when DECRYPTION_R2_TIMEOUT_EN is defined.
module tb_decryption_r2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] exp_i = '0;
  logic [31:0] p_i = '0;
  logic [31:0] r2_i = '0;
  logic [31:0] c1;
  logic        c1_valid;
  logic        c1_ready = 1'b0;
  logic [31:0] c2 = '0;
  logic        c2_valid = 1'b0;
  logic [31:0] r1_out;
  logic        busy;
  logic        done;
  logic        fail;

  int errors = 0;
  int checks = 0;

  decryption_r2 #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .exp(exp_i),
    .p(p_i),
    .r2(r2_i),
    .c1(c1),
    .c1_valid(c1_valid),
    .c1_ready(c1_ready),
    .c2(c2),
    .c2_valid(c2_valid),
    .r1_out(r1_out),
    .busy(busy),
    .done(done),
    .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_c1"}, c1, 0);
    chk({tag, "_c1v"}, c1_valid, 0);
    chk({tag, "_r1"}, r1_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask

  // Full exchange; the model is plain 64-bit modulo and xor.
  task automatic exchange(input logic [63:0] e, input logic [31:0] pp,
                          input logic [31:0] r2v, input logic [31:0] c2v,
                          input int low, input bit tmo_case);
    longint unsigned k;
    logic [31:0] kk;
    logic [31:0] r1x;
    bit rej;
    int n;
    k = 0;
    if (pp != 0) k = e % {32'd0, pp};
    kk = k[31:0];
    exp_i = e;
    p_i = pp;
    r2_i = r2v;
    start = 1'b1;
    c1_ready = (low == 0);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (pp == 0) begin
      chk("p0_done", done, 1);
      chk("p0_fail", fail, 1);
      chk("p0_c1v", c1_valid, 0);
      chk("p0_r1", r1_out, 0);
      step();
      chk("p0_done_clr", done, 0);
      chk("p0_busy_clr", busy, 0);
      chk("p0_c1v_after", c1_valid, 0);
      return;
    end
    // A start while busy (with p=0 presented) must be ignored.
    p_i = 32'd0;
    exp_i = ~e;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!c1_valid && n < 200) begin
      chk("no_done_in_mod", done, 0);
      step();
      n++;
    end
    // Visible after edge E0+64, so the responder samples it at E0+65.
    chk("c1_latency", n, 64);
    chk("c1_value", c1, kk ^ r2v);
    for (int i = 0; i < low; i++) begin
      chk("c1_hold", c1, kk ^ r2v);
      chk("c1v_hold", c1_valid, 1);
      step();
    end
    c1_ready = 1'b1;
    // Reject code on the SEND->WAIT edge must not be sampled.
    c2 = 32'd0;
    c2_valid = 1'b1;
    step();
    c2_valid = 1'b0;
    c1_ready = 1'b0;
    chk("c1v_drop", c1_valid, 0);
    chk("no_done_xfer", done, 0);
    chk("busy_wait", busy, 1);
    if (tmo_case) begin
      n = 0;
      while (!done && n < 100) begin
        step();
        n++;
      end
      chk("timeout_cycles", n, 16);
      chk("timeout_fail", fail, 1);
      chk("timeout_r1", r1_out, 0);
      step();
      chk("timeout_idle", busy, 0);
      return;
    end
    repeat ($urandom_range(3)) begin
      step();
      chk("wait_no_done", done, 0);
    end
    c2 = c2v;
    c2_valid = 1'b1;
    step();
    c2_valid = 1'b0;
    c2 = $urandom;
    rej = (c2v == 32'd0);
    r1x = rej ? 32'd0 : (c2v ^ kk);
    chk("done", done, 1);
    chk("fail", fail, rej);
    chk("r1_out", r1_out, r1x);
    step();
    chk("done_pulse", done, 0);
    chk("fail_low", fail, 0);
    chk("idle", busy, 0);
    chk("r1_hold", r1_out, r1x);
  endtask

  initial begin
    logic [63:0] re;
    logic [31:0] rp;
    step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();
    chk_idle_zero("post_reset");

    exchange(64'd100, 32'd7, 32'h5, 32'hB, 0, 1'b0);
    exchange(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB, 32'h0, 32'h18, 0, 1'b0);
    exchange(64'd100, 32'd7, 32'h5, 32'h0, 0, 1'b0);
    exchange(64'd100, 32'd0, 32'h5, 32'hB, 0, 1'b0);
    exchange(64'd100, 32'd7, 32'h5, 32'hB, 3, 1'b0);

    // Reset in MOD cycle 30 abandons the exchange.
    exp_i = 64'd100;
    p_i = 32'd7;
    r2_i = 32'h5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    rst = 1'b1;
    #1;
    chk_idle_zero("mid_reset");
    step();
    chk_idle_zero("mid_reset_hold");
    rst = 1'b0;
    step();
    exchange(64'd100, 32'd7, 32'h5, 32'hB, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      re = {$urandom, $urandom};
      rp = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (rp == 0) rp = 32'd1;
      exchange(re, rp, $urandom, (i == 5) ? 32'd0 : $urandom,
               int'($urandom_range(2)), 1'b0);
    end

`ifdef DECRYPTION_R2_TIMEOUT_EN
    exchange(64'd100, 32'd7, 32'h5, 32'hB, 0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decryption_r2.md
# decryption_r2

Initiator-side counterpart of the key-confirmation responder in the Diffie-Hellman exchange. From the shared secret `exp` and modulus `p`, it derives the session key k = exp mod p with a bit-serial modulo unit and emits challenge c1 = k ^ r2. It then waits for the responder's c2 and recovers the responder nonce r1 = c2 ^ k, or flags failure. It sits between the exponentiation stage (source of `exp`) and the link to the responder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024, maximum WAIT cycles before failure; only used when `DECRYPTION_R2_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `exp`  in  64  shared secret; latched on accepted `start`.
- `p`  in  32  modulus; latched on accepted `start`.
- `r2`  in  32  local nonce; latched on accepted `start`.
- `c1`  out  32  challenge k ^ r2.
- `c1_valid`  out  1  challenge is valid.
- `c1_ready`  in  1  responder accepts the challenge.
- `c2`  in  32  responder reply.
- `c2_valid`  in  1  reply valid; sampled only in WAIT.
- `r1_out`  out  32  recovered responder nonce.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fail`  out  1  qualifies `done`: 1 means reject.

## Operation
- States: IDLE, MOD, SEND, WAIT, FIN.
- IDLE:
  - On `start`, latch `exp`, `p`, `r2`.
  - If `p==0`, go to FIN with fail.
  - Otherwise clear the 33-bit remainder, set the bit counter to 63, and go to MOD.
- MOD, one bit per cycle, MSB of `exp` first:
  - t = {rem[31:0], exp_bit}.
  - rem = (t >= p) ? t - p : t.
  - After 64 cycles k = rem[31:0] (always < p); go to SEND.
- SEND:
  - `c1` = k ^ r2; `c1_valid`=1.
  - `c1` and `c1_valid` are held stable until the cycle in which `c1_ready` is 1, then go to WAIT.
- WAIT:
  - On `c2_valid`, if `c2==0` (responder reject code), go to FIN with fail.
  - Otherwise register `r1_out` = c2 ^ k and go to FIN with pass.
- FIN: `done`=1 for one cycle, `fail` per verdict, then return to IDLE.
- `r1_out` holds its value until the next accepted `start`, which clears it to 0. On fail it is 0.
- `start` outside IDLE is ignored. `c2_valid` outside WAIT is ignored.
- Inputs `exp`, `p`, `r2` may change freely after they are latched.

## Timing
- Reset values: `c1`=0, `c1_valid`=0, `r1_out`=0, `busy`=0, `done`=0, `fail`=0; state IDLE; remainder and counters 0.
- Reset asserted mid-operation: immediate return to all reset values; the exchange is abandoned with no `done`.
- `start` sampled at edge E0 → MOD cycles E0+1..E0+64 → `c1_valid` high from edge E0+65.
- With `c1_ready` already high, SEND lasts 1 cycle. Each low cycle of `c1_ready` adds one cycle.
- `c2_valid` sampled at edge Ew → `done` high for the cycle after Ew.
- `p==0`: `done` and `fail` go high the cycle after `start`; `c1_valid` never asserts.
- `c2_valid` in the same cycle as the SEND→WAIT transition is not sampled; WAIT begins on the next edge.
- `fail` is 0 whenever `done` is 0.

## Configuration
- `DECRYPTION_R2_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After `TIMEOUT_CYCLES` consecutive WAIT cycles without `c2_valid`, go to FIN with `fail`=1.
  - A `c2_valid` arriving in the same cycle the count expires wins.
- Not defined: no counter; WAIT lasts indefinitely until `c2_valid` or reset.

## Test plan
- exp=100, p=7, r2=0x5; `c1_ready`=1 → `c1`=0x7 (k=2) with `c1_valid` at E0+65. Then c2=0xB → `r1_out`=0x9, `done`=1, `fail`=0.
- exp=0xFFFF_FFFF_FFFF_FFFF, p=0xFFFF_FFFB, r2=0 → `c1`=0x18. Then c2=0x18 → `r1_out`=0.
- Same as first scenario, but c2=0 → `done`=1, `fail`=1, `r1_out`=0.
- p=0 → `done` and `fail` high on the cycle after `start`; `c1_valid` stays 0.
- `c1_ready` held low for 3 cycles in SEND → `c1`=0x7 and `c1_valid` stable all 3 cycles. Also: a second `start` pulse while busy is ignored.
- Reset asserted at MOD cycle 30 → all outputs 0, IDLE. A new `start` then completes normally. With `DECRYPTION_R2_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=16, no `c2_valid` → `done`/`fail` after 16 WAIT cycles.
